mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 30 +++
 rtl/arb_prio2.sv | 55 +++++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the boot-loader / run-time memory arbiter.
// Addresses and data use big-endian bit numbering [0:31]; bit 31 is the LSB.
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_DM = 1'b0,
        REQ_IF = 1'b1
    } req_id_t;

    typedef logic [0:ADDR_W-1] addr_t;
    typedef logic [0:DATA_W-1] data_t;

    // Clears the two byte-offset bits, which sit at [30:31] in this numbering.
    function automatic addr_t word_align(input addr_t a);
        addr_t r;
        r = a;
        r[ADDR_W-2:ADDR_W-1] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/arb_prio2.sv
// Two-way data-over-fetch priority select; ARB_STARVE_GUARD_EN adds a
// fetch-starvation counter that forces a fetch win after STALL_MAX losses.
module arb_prio2
    import mem_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
    parameter int unsigned STALL_MAX = 4
)
`endif
(
`ifdef ARB_STARVE_GUARD_EN
    input  logic    i_clk,
    input  logic    i_rst_n,
`endif
    input  logic    i_en,
    input  logic    i_dm_req,
    input  logic    i_if_req,
    output logic    o_gnt_valid,
    output req_id_t o_gnt_id
);

    logic w_dm_win;
    logic w_if_win;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [2:0] STALL_LIM = 3'(STALL_MAX);

    logic [2:0] r_starve;
    logic       w_force_if;

    assign w_force_if = i_if_req && (r_starve == STALL_LIM);
    assign w_dm_win   = i_en && i_dm_req && !w_force_if;
    assign w_if_win   = i_en && i_if_req && !w_dm_win;

    // Counts consecutive cycles in which a waiting fetch lost to data.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_starve <= 3'd0;
        end else if (i_en) begin
            if (!i_if_req || w_if_win) begin
                r_starve <= 3'd0;
            end else if (w_dm_win) begin
                r_starve <= r_starve + 3'd1;
            end
        end
    end
`else
    assign w_dm_win = i_en && i_dm_req;
    assign w_if_win = i_en && i_if_req && !w_dm_win;
`endif

    assign o_gnt_valid = w_dm_win || w_if_win;
    assign o_gnt_id    = w_dm_win ? REQ_DM : REQ_IF;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: SREC loader owns the port in LOAD, then data and
// fetch share it in RUN. Define ARB_STARVE_GUARD_EN to enable the fetch starvation guard.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned STALL_MAX = 4
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_load_valid,
    output logic    o_load_ready,
    input  addr_t   i_load_addr,
    input  data_t   i_load_data,
    input  logic    i_load_done,
    input  logic    i_if_req,
    output logic    o_if_gnt,
    input  addr_t   i_if_addr,
    output logic    o_if_rvalid,
    output data_t   o_if_rdata,
    input  logic    i_dm_req,
    input  logic    i_dm_we,
    output logic    o_dm_gnt,
    input  addr_t   i_dm_addr,
    input  data_t   i_dm_wdata,
    output logic    o_dm_rvalid,
    output data_t   o_dm_rdata,
    output logic    o_mem_en,
    output logic    o_mem_we,
    output addr_t   o_mem_addr,
    output data_t   o_mem_wdata,
    input  data_t   i_mem_rdata,
    output logic    o_run,
    output state_t  o_dbg_state
);

    if (STALL_MAX > 7) begin : g_stall_max_check
        $error("STALL_MAX does not fit the 3-bit starvation counter");
    end

    state_t  r_state;
    logic    r_load_ready;
    logic    r_run;
    logic    r_if_pend;
    logic    r_dm_pend;
    data_t   r_if_hold;
    data_t   r_dm_hold;

    logic    w_beat;
    logic    w_arb_en;
    logic    w_gnt_valid;
    req_id_t w_gnt_id;
    logic    w_dm_gnt;
    logic    w_if_gnt;
    logic    w_mem_en;
    logic    w_mem_we;
    addr_t   w_mem_addr;
    data_t   w_mem_wdata;

    // Reset low blocks every access so a reset cycle never issues a write.
    assign w_beat   = i_rst_n && r_load_ready && i_load_valid;
    assign w_arb_en = i_rst_n && (r_state == RUN);

    arb_prio2
`ifdef ARB_STARVE_GUARD_EN
    #(.STALL_MAX(STALL_MAX))
`endif
    u_arb (
`ifdef ARB_STARVE_GUARD_EN
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
`endif
        .i_en        (w_arb_en),
        .i_dm_req    (i_dm_req),
        .i_if_req    (i_if_req),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    assign w_dm_gnt = w_gnt_valid && (w_gnt_id == REQ_DM);
    assign w_if_gnt = w_gnt_valid && (w_gnt_id == REQ_IF);

    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_beat) begin
            w_mem_en    = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = i_load_addr;
            w_mem_wdata = i_load_data;
        end else if (w_dm_gnt) begin
            w_mem_en    = 1'b1;
            w_mem_we    = i_dm_we;
            w_mem_addr  = i_dm_addr;
            w_mem_wdata = i_dm_wdata;
        end else if (w_if_gnt) begin
            w_mem_en    = 1'b1;
            w_mem_addr  = i_if_addr;
        end
        w_mem_addr = word_align(w_mem_addr);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= LOAD;
            r_load_ready <= 1'b1;
            r_run        <= 1'b0;
            r_if_pend    <= 1'b0;
            r_dm_pend    <= 1'b0;
            r_if_hold    <= '0;
            r_dm_hold    <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (i_load_done) begin
                        r_state      <= DRAIN;
                        r_load_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_state <= RUN;
                    r_run   <= 1'b1;
                end
                RUN: begin
                end
                default: begin
                    r_state      <= LOAD;
                    r_load_ready <= 1'b1;
                    r_run        <= 1'b0;
                end
            endcase
            r_if_pend <= w_if_gnt;
            r_dm_pend <= w_dm_gnt && !i_dm_we;
            r_if_hold <= o_if_rdata;
            r_dm_hold <= o_dm_rdata;
        end
    end

    // Read data is taken straight from the memory in the response cycle and
    // parked in the hold register afterwards.
    assign o_if_rvalid = r_if_pend && i_rst_n;
    assign o_dm_rvalid = r_dm_pend && i_rst_n;
    assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : r_if_hold;
    assign o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : r_dm_hold;

    assign o_load_ready = r_load_ready;
    assign o_run        = r_run;
    assign o_if_gnt     = w_if_gnt;
    assign o_dm_gnt     = w_dm_gnt;
    assign o_mem_en     = w_mem_en;
    assign o_mem_we     = w_mem_we;
    assign o_mem_addr   = w_mem_addr;
    assign o_mem_wdata  = w_mem_wdata;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a phase/arbitration reference model predicts
// every cycle's memory port activity and each read response.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int STALL_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        load_valid, load_ready, load_done;
    logic [0:31] load_addr, load_data;
    logic        if_req, if_gnt, if_rvalid;
    logic [0:31] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [0:31] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [0:31] mem_addr, mem_wdata, mem_rdata;
    logic        run;
    state_t      dbg_state;

    mem_arbiter #(.STALL_MAX(STALL_MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_load_valid(load_valid), .o_load_ready(load_ready),
        .i_load_addr(load_addr), .i_load_data(load_data), .i_load_done(load_done),
        .i_if_req(if_req), .o_if_gnt(if_gnt), .i_if_addr(if_addr),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .o_dm_gnt(dm_gnt),
        .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_rvalid(dm_rvalid), .o_dm_rdata(dm_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_run(run), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory environment ----------------
    logic [31:0] sim_mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sim_mem[(32'(mem_addr) >> 2) & 32'hFF] = mem_wdata;
            else        mem_rdata <= sim_mem[(32'(mem_addr) >> 2) & 32'hFF];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        state_t      st;
        bit          lr, rn, en, we, ig, dg;
        logic [31:0] addr, wdata;
    } ctl_t;
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    ctl_t        exp_q[$];
    rsp_t        exp_if_q[$];
    rsp_t        exp_dm_q[$];
    logic [31:0] ref_mem [256];
    state_t      phase;
    int          losses;
    int          total = 0;
    int          bad = 0;
    bit          mon_on = 1'b0;
    logic [31:0] if_hold = '0;
    logic [31:0] dm_hold = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit rst_a, input bit lv, input bit ldn,
                        input logic [31:0] la, input logic [31:0] ld,
                        input bit ifr, input logic [31:0] ifa,
                        input bit dmr, input bit dmw,
                        input logic [31:0] dma, input logic [31:0] dmd);
        ctl_t e;
        rsp_t r;
        bit   dwin, iwin, forced;
        int   idx;
        @(posedge clk); #1;
        rst_n = !rst_a; load_valid = lv; load_done = ldn; load_addr = la; load_data = ld;
        if_req = ifr; if_addr = ifa; dm_req = dmr; dm_we = dmw; dm_addr = dma; dm_wdata = dmd;
        e.cyc = cyc; e.st = phase; e.lr = (phase == LOAD); e.rn = (phase == RUN);
        e.en = 0; e.we = 0; e.ig = 0; e.dg = 0; e.addr = '0; e.wdata = '0;
        if (rst_a) begin
            if (exp_if_q.size() > 0 && exp_if_q[0].cyc == cyc) void'(exp_if_q.pop_front());
            if (exp_dm_q.size() > 0 && exp_dm_q[0].cyc == cyc) void'(exp_dm_q.pop_front());
            phase = LOAD;
            losses = 0;
        end else if (phase == LOAD) begin
            if (lv) begin
                e.en = 1; e.we = 1; e.addr = la & 32'hFFFF_FFFC; e.wdata = ld;
                ref_mem[(e.addr >> 2) & 32'hFF] = ld;
            end
            if (ldn) phase = DRAIN;
        end else if (phase == DRAIN) begin
            phase = RUN;
        end else begin
            forced = GUARD && ifr && (losses == STALL_MAX);
            dwin = dmr && !forced;
            iwin = ifr && !dwin;
            if (dwin) begin
                e.dg = 1; e.en = 1; e.we = dmw; e.addr = dma & 32'hFFFF_FFFC;
                idx = int'((e.addr >> 2) & 32'hFF);
                if (dmw) begin
                    e.wdata = dmd;
                    ref_mem[idx] = dmd;
                end else begin
                    r.cyc = cyc + 1; r.data = ref_mem[idx];
                    exp_dm_q.push_back(r);
                end
            end else if (iwin) begin
                e.ig = 1; e.en = 1; e.addr = ifa & 32'hFFFF_FFFC;
                r.cyc = cyc + 1; r.data = ref_mem[(e.addr >> 2) & 32'hFF];
                exp_if_q.push_back(r);
            end
            if (!ifr || iwin) losses = 0;
            else              losses++;
        end
        exp_q.push_back(e);
    endtask

    task automatic rnd_step(input bit rst_a, input bit ldn);
        step(rst_a, 1'($urandom_range(0, 1)), ldn, 32'($urandom_range(0, 1023)), $urandom,
             ($urandom_range(0, 9) < 6), 32'($urandom_range(0, 1023)),
             ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 4),
             32'($urandom_range(0, 1023)), $urandom);
    endtask

    task automatic idle();
        step(0, 0, 0, '0, '0, 0, '0, 0, 0, '0, '0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        if (mon_on && !rst_n) begin
            if_hold = '0;
            dm_hold = '0;
        end
    end

    always @(negedge clk) begin
        ctl_t e;
        rsp_t r;
        bit   v;
        if (mon_on) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("state", 32'(dbg_state), 32'(e.st));
                chk("load_ready", 32'(load_ready), 32'(e.lr));
                chk("run", 32'(run), 32'(e.rn));
                chk("mem_en", 32'(mem_en), 32'(e.en));
                chk("if_gnt", 32'(if_gnt), 32'(e.ig));
                chk("dm_gnt", 32'(dm_gnt), 32'(e.dg));
                if (e.en) begin
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                end
            end
            v = exp_if_q.size() > 0 && exp_if_q[0].cyc == cyc;
            chk("if_rvalid", 32'(if_rvalid), 32'(v));
            if (v) begin
                r = exp_if_q.pop_front();
                chk("if_rdata", if_rdata, r.data);
                if_hold = r.data;
            end else begin
                chk("if_rdata_hold", if_rdata, if_hold);
            end
            v = exp_dm_q.size() > 0 && exp_dm_q[0].cyc == cyc;
            chk("dm_rvalid", 32'(dm_rvalid), 32'(v));
            if (v) begin
                r = exp_dm_q.pop_front();
                chk("dm_rdata", dm_rdata, r.data);
                dm_hold = r.data;
            end else begin
                chk("dm_rdata_hold", dm_rdata, dm_hold);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            sim_mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst_n = 1'b0; load_valid = 0; load_done = 0; load_addr = '0; load_data = '0;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        phase = LOAD;
        losses = 0;
        @(posedge clk);
        mon_on = 1'b1;

        // reset cycles with live requests: nothing may reach memory
        step(1, 1, 0, 32'h40, 32'h1111_1111, 1, 32'h0, 1, 1, 32'h44, 32'h2222_2222);
        step(1, 1, 0, 32'h40, 32'h1111_1111, 1, 32'h0, 1, 1, 32'h44, 32'h2222_2222);
        idle();

        // loader beats; fetch/data requests must be ignored
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 32'(i * 4), 32'hDEAD_BEEF + 32'(i), 1, 32'h0, 1, 0, 32'h0, 32'h0);
        step(0, 1, 1, 32'h10, 32'hDEAD_BEF3, 1, 32'h0, 0, 0, 32'h0, 32'h0);
        // drain cycle with everything asserted
        step(0, 1, 0, 32'h14, 32'h5555_5555, 1, 32'h8, 1, 1, 32'h24, 32'h6666_6666);

        // unaligned fetch, then contended data write
        step(0, 0, 0, '0, '0, 1, 32'h0000_0006, 0, 0, '0, '0);
        step(0, 1, 0, 32'h0, 32'h7777_7777, 1, 32'h0000_0008, 1, 1, 32'h20, 32'hCAFE_F00D);
        idle();

        // both held high: starvation guard decides the fifth cycle
        for (int i = 0; i < 6; i++)
            step(0, 0, 0, '0, '0, 1, 32'(i * 4), 1, 0, 32'h20, '0);
        idle();

        for (int i = 0; i < 300; i++) rnd_step(0, 0);

        // fetch read followed immediately by reset
        step(0, 0, 0, '0, '0, 1, 32'h4, 0, 0, '0, '0);
        step(1, 1, 0, 32'h30, 32'h1234_5678, 1, 32'h8, 1, 0, 32'hC, '0);
        step(1, 0, 0, '0, '0, 0, '0, 0, 0, '0, '0);

        for (int i = 0; i < 20; i++) rnd_step(0, 0);
        step(0, 1, 1, 32'h3C, $urandom, 1, '0, 1, 0, '0, '0);
        for (int i = 0; i < 120; i++) rnd_step(0, 0);
        for (int i = 0; i < 3; i++) idle();

        @(negedge clk); #1;
        chk("leftover_expectations", 32'(exp_q.size() + exp_if_q.size() + exp_dm_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
